display_scan_7seg: RTL
======================

# display_scan_7seg

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It sits directly downstream of the BCD splitter, which produces units/tens/hundreds digits plus `done` and `negative`. The block snapshots those values once per refresh frame and scans them onto the shared segment bus, one digit at a time. Digit 3 is the sign position: only segment g lights, and only for negative results.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2. The prescaler width is `$clog2(REFRESH_DIV)`.
- `clk` in 1: system clock; every register is clocked on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `unidades` in 4: BCD units digit.
- `decenas` in 4: BCD tens digit.
- `centenas` in 4: BCD hundreds digit.
- `done` in 1: the result is valid and should be displayed.
- `negative` in 1: the result is negative; lights segment g on digit 3.
- `an` out 4: digit anodes, active-low; `an[0]` is units and `an[3]` is sign.
- `seg` out 7: segments, active-low, ordered `{g,f,e,d,c,b,a}`; `seg[0]` is segment a.

## Operation
- **Prescaler.** Counts 0..REFRESH_DIV-1 and wraps to 0. `tick` is asserted in the cycle where the count equals REFRESH_DIV-1.
- **Digit index.** 2-bit `idx` advances on `tick`: 0→1→2→3→0.
- **Snapshot.** Registers capture `unidades`, `decenas`, `centenas`, `done` and `negative` on a `tick` where `idx`==3 (the frame boundary).
  - Input changes at any other time are ignored until the next boundary.
  - Every frame therefore shows one consistent value.
- **Digit source.** Decoded from the snapshot:
  - `idx` 0: units.
  - `idx` 1: tens.
  - `idx` 2: hundreds.
  - `idx` 3: sign.
- **Decoder.** BCD 0–9 maps to standard glyphs. Codes A–F are blanked (`seg`=7'b1111111); they are never displayed as hex.
- **Sign digit.** Shows 7'b0111111 (g only) if the snapshot `negative`=1 and `done`=1; otherwise blank.
- **Not done.** If the snapshot `done`=0, all four digits are blank. The anodes keep scanning.
- **Anode.** `an` = ~(1<<idx) at all times out of reset, including while the digit is blank.

## Timing
- **Reset values.**
  - `an`=4'b1111 and `seg`=7'b1111111.
  - Prescaler=0 and `idx`=0.
  - All snapshot registers=0, including `done`=0.
- **Registered outputs.** `an` and `seg` change on the same edge, one cycle after `idx` changes, so segment/anode skew cannot cause ghosting.
- **Dwell and frame.** Each digit stays lit for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- **First cycle after reset.** `idx`=0 is driven: `an`=4'b1110 with `seg` blank. This holds because the snapshot `done`=0 until the first frame boundary.
- **Data latency.** An input value is displayed on digit 0 starting one cycle after the frame-boundary `tick` that captured it. Worst case, a value appears 4·REFRESH_DIV+1 cycles after it is applied.
- **Reset during a scan.** `rst` overrides `tick` and the snapshot capture. On the next edge every output returns to its reset value and the scan restarts at `idx`=0.
- **Inputs held constant.** The display is steady; there is no flicker at the frame wrap.

## Configuration
- Macro: `LEADING_ZERO_BLANK_EN`.
- **Defined:** leading zeros are blanked.
  - Hundreds is blanked if it is 0.
  - Tens is blanked if both hundreds and tens are 0.
  - Units is never blanked, so a value of 0 shows as "0".
  - The sign digit is unaffected, so −5 shows as "-  5" with digits 2 and 1 blank.
- **Undefined:** all three numeric digits always show their glyph. Value 7 shows as "007".

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset.** Hold `rst` for 3 cycles with `done`=1 and inputs 1/2/3.
  - Required: `an`=1111 and `seg`=1111111 during reset.
  - Required: after release, the first full frame shows blank segments while `an` scans 1110, 1101, 1011, 0111 with 4 cycles each.
- **Positive value.** `done`=1, `negative`=0, digits 3/2/1 (units/tens/hundreds).
  - Required, in the frame after the boundary: `an`=1110 `seg`=0110000; `an`=1101 `seg`=0100100; `an`=1011 `seg`=1111001; `an`=0111 `seg`=1111111.
- **Negative value with blanking.** `LEADING_ZERO_BLANK_EN` defined; `done`=1, `negative`=1, digits 5/0/0.
  - Required: units `seg`=0010010; tens and hundreds `seg`=1111111; sign `seg`=0111111.
  - Without the macro: tens and hundreds `seg`=1000000.
- **Change mid-frame.** Units changes from 3 to 8 while `idx`=1.
  - Required: the display keeps 3 for the rest of the frame and shows 8 (`seg`=0000000) from the next frame boundary + 1 cycle.
- **Invalid BCD.** Units=4'hA with `done`=1.
  - Required: digit 0 `seg`=1111111 while the other digits are unaffected.
- **Reset mid-scan.** Assert `rst` for 1 cycle while `idx`=2 and the prescaler is at 1.
  - Required: on the next edge `an`=1111 and `seg`=1111111.
  - Required: the next cycle shows `an`=1110, and the display stays blank until a new frame boundary capture.

Source files
------------

// File: rtl/display_scan_7seg.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_7seg #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] unidades,
  input  logic [3:0] decenas,
  input  logic [3:0] centenas,
  input  logic       done,
  input  logic       negative,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    uni_q, dec_q, cen_q;
  logic          done_q, neg_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic          capture;
  logic          blankTens, blankHund;

  // Active-low glyphs ordered {g,f,e,d,c,b,a}; non-BCD codes stay dark.
  function automatic logic [6:0] decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = BLANK;
    endcase
  endfunction

  assign tick    = (cnt_q == LAST);
  assign capture = tick && (idx_q == 2'd3);

`ifdef LEADING_ZERO_BLANK_EN
  assign blankHund = (cen_q == 4'd0);
  assign blankTens = (cen_q == 4'd0) && (dec_q == 4'd0);
`else
  assign blankHund = 1'b0;
  assign blankTens = 1'b0;
`endif

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    an_d  = ~(4'b0001 << idx_q);
    seg_d = BLANK;
    if (done_q) begin
      case (idx_q)
        2'd0: seg_d = decode(uni_q);
        2'd1: seg_d = blankTens ? BLANK : decode(dec_q);
        2'd2: seg_d = blankHund ? BLANK : decode(cen_q);
        default: seg_d = neg_q ? MINUS : BLANK;
      endcase
    end
  end

  // Outputs are registered from the current index so anode and segments switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      uni_q  <= 4'd0;
      dec_q  <= 4'd0;
      cen_q  <= 4'd0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      an_q   <= 4'b1111;
      seg_q  <= BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      if (capture) begin
        uni_q  <= unidades;
        dec_q  <= decenas;
        cen_q  <= centenas;
        done_q <= done;
        neg_q  <= negative;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
